brick_field: RTL and testbench
==============================

Name: brick_field

Overview:
- Parametrised brick-array engine for the 160x120, 3-bit-colour VGA breakout game.
- Holds a ROWS x COLS grid of bricks, each with multi-hit points, and answers ball-position collision queries with a per-brick scan.
- Streams brick pixels (full redraw, or dirty bricks only) one per clock into the vga_adapter x/y/colour/plot inputs.
- Replaces hand-unrolled per-brick update/draw states in the game FSM.

Parameters:
- COLS, 5, bricks per row
- ROWS, 2, brick rows; N = ROWS*COLS
- BRICK_W, 8, brick width in pixels
- BRICK_H, 2, brick height in pixels
- ORIGIN_X, 15, x of brick 0 top-left
- ORIGIN_Y, 30, y of brick 0 top-left
- PITCH_X, 30, x step between columns
- PITCH_Y, 6, y step between rows
- HP_BITS, 2, hit-point width (1..2)
- INIT_HP, 2, hit points loaded by init (1..2^HP_BITS-1)

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- idle  out  1  engine ready; all requests are accepted only while idle=1
- init_req  in  1  restore all bricks to INIT_HP
- query_valid  in  1  collision query request
- query_x  in  8  ball x
- query_y  in  8  ball y
- hit_valid  out  1  one-cycle query result strobe
- hit  out  1  1 = brick struck
- hit_index  out  clog2(N)  struck brick, row*COLS+col
- draw_req  in  1  start draw pass
- draw_all  in  1  sampled with draw_req: 1 = all bricks, 0 = dirty bricks only
- draw_done  out  1  one-cycle strobe at end of draw pass
- plot  out  1  pixel valid
- x  out  8  pixel x
- y  out  8  pixel y
- colour  out  3  pixel colour
- remaining  out  clog2(N+1)  bricks with hp != 0
- cleared  out  1  remaining == 0

Behaviour:
- Reset (async, any state): state IDLE, all hp = 0, all dirty = 0, all outputs 0 except idle = 1 and cleared = 1. Any operation in progress is abandoned.
- Brick i = r*COLS+c sits at bx = ORIGIN_X + c*PITCH_X, by = ORIGIN_Y + r*PITCH_Y.
- Parameters must keep every brick inside 160x120. An elaboration-time check enforces this; no wrap handling exists.
- Colour from hp: 0 = 000 (erase), 1 = 010, 2 = 110, 3 = 100.
- States: IDLE, INIT, QUERY, DRAW.
- Request acceptance: requests are accepted only in IDLE. If several are asserted together, priority is init_req > query_valid > draw_req. A request that is not accepted is dropped, so requesters hold it until they see the accepting edge (idle was 1).
- INIT:
  - Writes hp = INIT_HP and dirty = 1 to brick i in cycle i, for N cycles.
  - Returns to IDLE; remaining = N.
- QUERY:
  - query_x and query_y are latched at acceptance (edge k).
  - Brick i is tested in cycle k+1+i. It is hit if hp != 0, bx <= qx <= bx+BRICK_W-1 and by <= qy <= by+BRICK_H-1.
  - The first hit stops the scan: hp decrements, dirty is set, and remaining decrements if hp reaches 0.
  - hit_valid = 1, hit = 1, hit_index = i in cycle k+2+i.
  - On a miss: hit_valid = 1, hit = 0, hit_index = 0 in cycle k+1+N.
  - At most one brick is hit per query. idle rises in the same cycle as hit_valid.
- DRAW:
  - Visits bricks 0..N-1 in order.
  - A selected brick (draw_all, or dirty = 1) emits BRICK_W*BRICK_H pixels, one per cycle, row-major: x from bx..bx+BRICK_W-1 inner, y from by..by+BRICK_H-1 outer. plot = 1 and colour comes from hp. Its dirty bit clears after its last pixel.
  - An unselected brick costs exactly 1 cycle with plot = 0.
  - After brick N-1: draw_done = 1 for one cycle, back to IDLE.
  - plot = 0 whenever no pixel is emitted.
- hp never underflows; bricks with hp = 0 never match a query.
- remaining and cleared are registered and update in the cycle after the hp change.

Decomposition:
- Package brick_field_pkg holds:
  - state encoding;
  - colour constants BLACK 000, GREEN 010, YELLOW 110, RED 100;
  - hp-to-colour function;
  - screen limits 160/120.
- Sub-module rect_plotter:
  - start/w/h/x0/y0 in;
  - x, y, plot, done out;
  - one pixel per cycle.
  - Reused later by the paddle and ball drawers.

Test Plan:
- Reset with defaults -> idle=1, plot=0, remaining=0, cleared=1, hit_valid=0.
- init_req, then after idle, draw_req with draw_all=1 -> 160 plots.
  - First pixel (15,30) colour 110; last pixel (142,37) colour 110.
  - draw_done strobe one cycle after the last pixel; remaining=10.
- query (18,31) accepted at edge k -> hit_valid at k+2, hit=1, hit_index=0.
  - Dirty draw then gives 16 plots at x 15..22, y 30..31, colour 010, plus 9 skip cycles.
  - Repeat the query -> remaining=9 and dirty draw colour 000.
  - A third identical query -> miss, hit_valid at k+11.
- Edge queries on brick 0 -> (14,30) miss, (23,30) miss, (22,31) hit, (15,32) miss.
  - Brick 9 at (142,37) -> hit_index=9 at k+11.
- init_req and query_valid asserted in the same cycle -> INIT accepted.
  - idle=0 for 10 cycles; query_valid must stay high and is accepted at the first idle edge.
- Assert reset mid-draw (pixel 5) -> plot=0 and idle=1 asynchronously; after release remaining=0, cleared=1.
- Hit all 10 bricks twice -> cleared=1 one cycle after the last hit; further queries return hit=0.

Source files
------------

// File: rtl/brick_field_pkg.sv
// rtl/brick_field_pkg.sv - shared state encoding, colours and helpers for the brick field engine
// Purpose: types and constants imported by brick_field and its drawers.
//   state_t    : engine FSM states
//   BLACK..RED : 3-bit VGA colours
//   hp_colour  : hit points -> brick colour (0 erases)
//   SCREEN_W/H : 160x120 playfield limits
package brick_field_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_QUERY,
      ST_DRAW
   } state_t;

   localparam logic [2:0] BLACK  = 3'b000;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b110;
   localparam logic [2:0] RED    = 3'b100;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   function automatic logic [2:0] hp_colour(input logic [1:0] hp);
      case (hp)
         2'd0:    hp_colour = BLACK;
         2'd1:    hp_colour = GREEN;
         2'd2:    hp_colour = YELLOW;
         default: hp_colour = RED;
      endcase
   endfunction

endpackage

// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - emits one pixel per clock covering a w x h rectangle
// Purpose: row-major rectangle walker feeding vga_adapter x/y/plot.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : begin a rectangle; the first pixel is emitted in the same cycle
//   w, h         : rectangle size (>= 1), held stable until done
//   x0, y0       : top-left corner, held stable until done
//   x, y, plot   : current pixel (x/y are 0 when plot = 0)
//   done         : current pixel is the last one of the rectangle
module rect_plotter (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] w,
   input  logic [7:0] h,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   output logic [7:0] x,
   output logic [7:0] y,
   output logic       plot,
   output logic       done
);

   logic       active;
   logic [7:0] cx, cy;
   logic [7:0] ox, oy;
   logic       last_col, last_row;

   // While idle the offsets read as zero so a start pixel needs no setup cycle;
   // start is ignored once a rectangle is in flight.
   assign ox       = active ? cx : 8'd0;
   assign oy       = active ? cy : 8'd0;
   assign plot     = start | active;
   assign last_col = (ox == w - 8'd1);
   assign last_row = (oy == h - 8'd1);
   assign done     = plot & last_col & last_row;
   assign x        = plot ? x0 + ox : 8'd0;
   assign y        = plot ? y0 + oy : 8'd0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active <= 1'b0;
         cx     <= 8'd0;
         cy     <= 8'd0;
      end else if (plot) begin
         if (done) begin
            active <= 1'b0;
            cx     <= 8'd0;
            cy     <= 8'd0;
         end else begin
            active <= 1'b1;
            if (last_col) begin
               cx <= 8'd0;
               cy <= oy + 8'd1;
            end else begin
               cx <= ox + 8'd1;
               cy <= oy;
            end
         end
      end
   end

endmodule

// File: rtl/brick_field.sv
// rtl/brick_field.sv - brick grid with multi-hit points, collision scan and pixel streamer
// Purpose: holds ROWS x COLS bricks, answers ball collision queries, redraws bricks.
// Ports:
//   clock, reset                  : CLOCK_50, asynchronous active-high reset
//   idle                          : requests are accepted only while high
//   init_req                      : reload every brick with INIT_HP
//   query_valid, query_x/y        : collision query; hit_valid/hit/hit_index answer it
//   draw_req, draw_all            : draw pass (all bricks or dirty ones); draw_done ends it
//   plot, x, y, colour            : pixel stream into vga_adapter
//   remaining, cleared            : live brick count and all-cleared flag (registered)
module brick_field
   import brick_field_pkg::*;
#(
   parameter int COLS     = 5,
   parameter int ROWS     = 2,
   parameter int BRICK_W  = 8,
   parameter int BRICK_H  = 2,
   parameter int ORIGIN_X = 15,
   parameter int ORIGIN_Y = 30,
   parameter int PITCH_X  = 30,
   parameter int PITCH_Y  = 6,
   parameter int HP_BITS  = 2,
   parameter int INIT_HP  = 2,
   localparam int N       = ROWS * COLS,
   localparam int HI_W    = (N > 1) ? $clog2(N) : 1,
   localparam int RW      = $clog2(N + 1)
) (
   input  logic            clock,
   input  logic            reset,
   output logic            idle,
   input  logic            init_req,
   input  logic            query_valid,
   input  logic [7:0]      query_x,
   input  logic [7:0]      query_y,
   output logic            hit_valid,
   output logic            hit,
   output logic [HI_W-1:0] hit_index,
   input  logic            draw_req,
   input  logic            draw_all,
   output logic            draw_done,
   output logic            plot,
   output logic [7:0]      x,
   output logic [7:0]      y,
   output logic [2:0]      colour,
   output logic [RW-1:0]   remaining,
   output logic            cleared
);

   if (ORIGIN_X + (COLS - 1) * PITCH_X + BRICK_W > SCREEN_W ||
       ORIGIN_Y + (ROWS - 1) * PITCH_Y + BRICK_H > SCREEN_H) begin : g_bad_geometry
      $error("brick_field: brick grid does not fit inside the screen");
   end
   if (HP_BITS < 1 || HP_BITS > 2 || INIT_HP < 1 || INIT_HP > (1 << HP_BITS) - 1 || N < 2) begin : g_bad_hp
      $error("brick_field: bad hit-point or grid size parameters");
   end

   state_t            state, state_nx;
   logic [RW-1:0]     idx;          // brick being written, tested or drawn; N marks end of draw
   logic [HI_W-1:0]   bi;
   logic [HP_BITS-1:0] hp [N];
   logic [N-1:0]      dirty;
   logic [7:0]        qx, qy;
   logic              draw_all_r;
   logic [7:0]        bx_tab [N];
   logic [7:0]        by_tab [N];
   logic              last_brick, draw_end, q_match, sel;
   logic              pl_start, pl_plot, pl_done;
   logic [7:0]        pl_x, pl_y;
   logic [RW-1:0]     live;

   for (genvar i = 0; i < N; i++) begin : g_pos
      assign bx_tab[i] = 8'(ORIGIN_X + (i % COLS) * PITCH_X);
      assign by_tab[i] = 8'(ORIGIN_Y + (i / COLS) * PITCH_Y);
   end

   assign bi         = HI_W'(idx);
   assign last_brick = (idx == RW'(N - 1));
   assign draw_end   = (idx == RW'(N));

   assign q_match = (state == ST_QUERY) && (hp[bi] != '0) &&
                    (qx >= bx_tab[bi]) && (qx <= bx_tab[bi] + 8'(BRICK_W - 1)) &&
                    (qy >= by_tab[bi]) && (qy <= by_tab[bi] + 8'(BRICK_H - 1));

   assign sel       = draw_all_r | dirty[bi];
   assign pl_start  = (state == ST_DRAW) && !draw_end && sel;
   assign draw_done = (state == ST_DRAW) && draw_end;

   rect_plotter u_plotter (
      .clock (clock),
      .reset (reset),
      .start (pl_start),
      .w     (8'(BRICK_W)),
      .h     (8'(BRICK_H)),
      .x0    (bx_tab[bi]),
      .y0    (by_tab[bi]),
      .x     (pl_x),
      .y     (pl_y),
      .plot  (pl_plot),
      .done  (pl_done)
   );

   assign plot   = pl_plot;
   assign x      = pl_x;
   assign y      = pl_y;
   assign colour = pl_plot ? hp_colour(2'(hp[bi])) : BLACK;

   always_comb begin
      live = '0;
      for (int i = 0; i < N; i++)
         if (hp[i] != '0) live = live + RW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      idle     = 1'b0;
      case (state)
         ST_IDLE: begin
            idle = 1'b1;
            if (init_req)         state_nx = ST_INIT;
            else if (query_valid) state_nx = ST_QUERY;
            else if (draw_req)    state_nx = ST_DRAW;
         end
         ST_INIT:  if (last_brick) state_nx = ST_IDLE;
         ST_QUERY: if (q_match || last_brick) state_nx = ST_IDLE;
         ST_DRAW:  if (draw_end) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx        <= '0;
         for (int i = 0; i < N; i++) hp[i] <= '0;
         dirty      <= '0;
         qx         <= 8'd0;
         qy         <= 8'd0;
         draw_all_r <= 1'b0;
         hit_valid  <= 1'b0;
         hit        <= 1'b0;
         hit_index  <= '0;
         remaining  <= '0;
         cleared    <= 1'b1;
      end else begin
         hit_valid <= 1'b0;
         hit       <= 1'b0;
         hit_index <= '0;
         remaining <= live;
         cleared   <= (live == '0);
         case (state)
            ST_IDLE: begin
               idx <= '0;
               if (!init_req && query_valid) begin
                  qx <= query_x;
                  qy <= query_y;
               end
               if (!init_req && !query_valid && draw_req) draw_all_r <= draw_all;
            end
            ST_INIT: begin
               hp[bi]    <= HP_BITS'(INIT_HP);
               dirty[bi] <= 1'b1;
               idx       <= idx + RW'(1);
            end
            ST_QUERY: begin
               // First matching brick ends the scan, so at most one brick loses a point.
               if (q_match) begin
                  hp[bi]    <= hp[bi] - HP_BITS'(1);
                  dirty[bi] <= 1'b1;
                  hit_valid <= 1'b1;
                  hit       <= 1'b1;
                  hit_index <= bi;
               end else if (last_brick) begin
                  hit_valid <= 1'b1;
               end else begin
                  idx <= idx + RW'(1);
               end
            end
            ST_DRAW: begin
               if (!draw_end) begin
                  if (!sel) begin
                     idx <= idx + RW'(1);
                  end else if (pl_done) begin
                     dirty[bi] <= 1'b0;
                     idx       <= idx + RW'(1);
                  end
               end
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_brick_field.sv
// tb/tb_brick_field.sv - directed scoreboard bench for brick_field
module tb_brick_field;

   localparam int N = 10;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      logic hit;
      int   idx;
      int   lat;
      int   live_before;
      int   live_after;
   } qres_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       idle;
   logic       init_req = 1'b0;
   logic       query_valid = 1'b0;
   logic [7:0] query_x = 8'd0;
   logic [7:0] query_y = 8'd0;
   logic       hit_valid, hit;
   logic [3:0] hit_index;
   logic       draw_req = 1'b0;
   logic       draw_all = 1'b0;
   logic       draw_done, plot;
   logic [7:0] x, y;
   logic [2:0] colour;
   logic [3:0] remaining;
   logic       cleared;

   int   total = 0;
   int   bad = 0;
   int   hp_m [N];
   logic dirty_m [N];
   pix_t  pix_q [$];
   qres_t q_q [$];

   brick_field dut (
      .clock       (CLOCK_50),
      .reset       (reset),
      .idle        (idle),
      .init_req    (init_req),
      .query_valid (query_valid),
      .query_x     (query_x),
      .query_y     (query_y),
      .hit_valid   (hit_valid),
      .hit         (hit),
      .hit_index   (hit_index),
      .draw_req    (draw_req),
      .draw_all    (draw_all),
      .draw_done   (draw_done),
      .plot        (plot),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .remaining   (remaining),
      .cleared     (cleared)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int bx_m(input int i);
      return 15 + (i % 5) * 30;
   endfunction

   function automatic int by_m(input int i);
      return 30 + (i / 5) * 6;
   endfunction

   function automatic logic [2:0] col_m(input int hp);
      case (hp)
         0:       return 3'b000;
         1:       return 3'b010;
         2:       return 3'b110;
         default: return 3'b100;
      endcase
   endfunction

   function automatic int live_m();
      int n = 0;
      for (int i = 0; i < N; i++) if (hp_m[i] != 0) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         hp_m[i] = 0;
         dirty_m[i] = 1'b0;
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < N; i++) begin
         hp_m[i] = 2;
         dirty_m[i] = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int c = 0;
      while (!idle && c < 500) begin
         tick();
         c++;
      end
      chk("wait_idle", idle, 1);
   endtask

   task automatic push_query(input int qx, input int qy);
      qres_t e;
      e.live_before = live_m();
      e.hit = 1'b0;
      e.idx = 0;
      e.lat = N;
      for (int i = 0; i < N; i++) begin
         if (hp_m[i] != 0 && qx >= bx_m(i) && qx <= bx_m(i) + 7 &&
             qy >= by_m(i) && qy <= by_m(i) + 1) begin
            e.hit = 1'b1;
            e.idx = i;
            e.lat = i + 1;
            hp_m[i]--;
            dirty_m[i] = 1'b1;
            break;
         end
      end
      e.live_after = live_m();
      q_q.push_back(e);
   endtask

   // Called right after the accepting edge; counts edges until the result strobe.
   task automatic wait_qres();
      qres_t e;
      int    c = 0;
      logic  seen = 1'b0;
      while (!seen && c <= N + 5) begin
         if (hit_valid) seen = 1'b1;
         else begin
            tick();
            c++;
         end
      end
      chk("qres_seen", seen, 1);
      if (q_q.size() > 0) begin
         e = q_q.pop_front();
         if (seen) begin
            chk("hit", hit, e.hit);
            chk("hit_index", hit_index, e.idx);
            chk("hit_latency", c, e.lat);
            chk("idle_with_result", idle, 1);
            chk("remaining_before", remaining, e.live_before);
            tick();
            chk("hit_valid_pulse", hit_valid, 0);
            chk("remaining_after", remaining, e.live_after);
            chk("cleared_after", cleared, (e.live_after == 0));
         end
      end
   endtask

   task automatic do_query(input int qx, input int qy);
      push_query(qx, qy);
      wait_idle();
      query_valid = 1'b1;
      query_x = 8'(qx);
      query_y = 8'(qy);
      tick();
      query_valid = 1'b0;
      wait_qres();
   endtask

   task automatic do_init();
      int c = 0;
      wait_idle();
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      while (!idle && c < 40) begin
         tick();
         c++;
      end
      chk("init_busy_cycles", c, N);
      model_init();
      tick();
      chk("init_remaining", remaining, N);
      chk("init_cleared", cleared, 0);
   endtask

   task automatic do_draw(input logic all_sel);
      pix_t e;
      int   t_exp = 0;
      int   plots_exp = 0;
      int   plots = 0;
      int   c = 0;
      logic done_seen = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (all_sel || dirty_m[i]) begin
            for (int py = 0; py < 2; py++)
               for (int px = 0; px < 8; px++) begin
                  e.x = 8'(bx_m(i) + px);
                  e.y = 8'(by_m(i) + py);
                  e.c = col_m(hp_m[i]);
                  pix_q.push_back(e);
               end
            t_exp += 16;
            plots_exp += 16;
            dirty_m[i] = 1'b0;
         end else begin
            t_exp += 1;
         end
      end
      wait_idle();
      draw_req = 1'b1;
      draw_all = all_sel;
      tick();
      draw_req = 1'b0;
      draw_all = 1'b0;
      while (!done_seen && c <= t_exp + 20) begin
         if (draw_done) done_seen = 1'b1;
         else begin
            if (plot) begin
               plots++;
               if (pix_q.size() > 0) begin
                  e = pix_q.pop_front();
                  chk("pixel_xyc", {x, y, colour}, e);
               end
            end
            tick();
            c++;
         end
      end
      chk("draw_done_seen", done_seen, 1);
      chk("draw_done_cycle", c, t_exp);
      chk("draw_plot_count", plots, plots_exp);
      chk("draw_done_no_plot", plot, 0);
      pix_q.delete();
      tick();
      chk("draw_done_pulse", draw_done, 0);
      chk("draw_back_idle", idle, 1);
      chk("draw_remaining", remaining, live_m());
   endtask

   initial begin
      int n;
      int c;
      model_reset();
      tick();
      tick();
      tick();
      reset = 1'b0;
      chk("rst_idle", idle, 1);
      chk("rst_plot", plot, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_cleared", cleared, 1);
      chk("rst_hit_valid", hit_valid, 0);
      chk("rst_draw_done", draw_done, 0);
      chk("rst_xyc", {x, y, colour}, 0);

      do_init();
      do_draw(1'b1);

      do_query(18, 31);
      do_draw(1'b0);
      do_query(18, 31);
      do_draw(1'b0);
      do_query(18, 31);

      do_init();
      do_query(14, 30);
      do_query(23, 30);
      do_query(22, 31);
      do_query(15, 32);
      do_query(142, 37);

      // Asynchronous reset in the middle of brick 0 (pixel index 5).
      wait_idle();
      draw_req = 1'b1;
      draw_all = 1'b1;
      tick();
      draw_req = 1'b0;
      draw_all = 1'b0;
      n = 0;
      c = 0;
      while (c < 40 && n < 6) begin
         if (plot) n++;
         if (n < 6) begin
            tick();
            c++;
         end
      end
      chk("mid_pixel5_x", x, 20);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_plot", plot, 0);
      chk("async_rst_idle", idle, 1);
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      tick();
      chk("post_rst_remaining", remaining, 0);
      chk("post_rst_cleared", cleared, 1);

      // init_req beats query_valid; query held until the first idle edge.
      wait_idle();
      init_req = 1'b1;
      query_valid = 1'b1;
      query_x = 8'd18;
      query_y = 8'd31;
      tick();
      init_req = 1'b0;
      c = 0;
      while (!idle && c < 40) begin
         tick();
         c++;
      end
      chk("prio_busy_cycles", c, N);
      chk("prio_no_result", hit_valid, 0);
      model_init();
      push_query(18, 31);
      tick();
      query_valid = 1'b0;
      wait_qres();

      do_init();
      for (int rep = 0; rep < 2; rep++)
         for (int i = 0; i < N; i++)
            do_query(bx_m(i) + 3, by_m(i) + 1);
      chk("all_cleared", cleared, 1);
      do_query(18, 31);
      do_query(142, 37);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
